rect_fill_sequencer: RTL and testbench

- Command-level front end for the HDMI SDRAM display writer.
- Accepts rectangle fill commands (x, y, w, h, colour) into a small command FIFO.
- Clips each command to the display window and splits it into one line-write per row.
- Drives each line-write into the writer's x_pos/y_pos/pixel/len/enable/busy handshake, so software issues one command per rectangle instead of one per row.

---
 rtl/rect_fill_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_rect_fill_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill_sequencer.sv
// Rectangle fill front end: queues fill commands, clips them to the display
// window and replays each surviving row as one line-write to the SDRAM display writer.
module rect_fill_sequencer #(
    parameter int H_DISP      = 1024,
    parameter int V_DISP      = 600,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_x,
    input  logic [15:0] cmd_y,
    input  logic [15:0] cmd_w,
    input  logic [15:0] cmd_h,
    input  logic [23:0] cmd_color,
    output logic [15:0] x_pos,
    output logic [15:0] y_pos,
    output logic [23:0] pixel,
    output logic [23:0] len,
    output logic        enable,
    input  logic        sys_vaild,
    input  logic        busy,
    output logic        idle,
    output logic        err,
    output logic [7:0]  drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(ACK_TIMEOUT) + 1;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] w;
        logic [15:0] h;
        logic [23:0] color;
    } cmd_t;

    typedef enum logic [2:0] {S_IDLE, S_CLIP, S_ISSUE, S_WAIT, S_NEXT} state_t;

    cmd_t        fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        cmd_ready_q, cmd_ready_d, idle_q, idle_d;
    logic        fifo_empty_s, push_s, pop_s;
    state_t      state_q, state_d;
    cmd_t        wk_q, wk_d;
    logic [15:0] x_pos_q, x_pos_d, y_pos_q, y_pos_d, rows_q, rows_d;
    logic [23:0] pixel_q, pixel_d, len_q, len_d;
    logic        enable_q, enable_d, err_q, err_d;
    logic [7:0]  drop_q, drop_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [16:0] avail_w_s, avail_h_s, row_w_s, row_h_s;
    logic        discard_s;

    // FIFO pointer bookkeeping; the extra MSB distinguishes full from empty.
    always_comb begin
        fifo_empty_s = (wr_ptr_q == rd_ptr_q);
        push_s       = cmd_valid & cmd_ready_q;
        wr_ptr_d     = wr_ptr_q + {{AW{1'b0}}, push_s};
        rd_ptr_d     = rd_ptr_q + {{AW{1'b0}}, pop_s};
        cmd_ready_d  = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                         (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
        idle_d       = (wr_ptr_d == rd_ptr_d) && (state_d == S_IDLE);
    end

    // Clip arithmetic in 17 bits so a huge width or an off-screen origin cannot wrap.
    always_comb begin
        avail_w_s = 17'(H_DISP) - {1'b0, wk_q.x};
        avail_h_s = 17'(V_DISP) - {1'b0, wk_q.y};
        row_w_s   = ({1'b0, wk_q.w} < avail_w_s) ? {1'b0, wk_q.w} : avail_w_s;
        row_h_s   = ({1'b0, wk_q.h} < avail_h_s) ? {1'b0, wk_q.h} : avail_h_s;
        discard_s = (wk_q.w == 16'd0) || (wk_q.h == 16'd0) ||
                    ({1'b0, wk_q.x} >= 17'(H_DISP)) || ({1'b0, wk_q.y} >= 17'(V_DISP));
    end

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        pop_s    = 1'b0;
        wk_d     = wk_q;
        x_pos_d  = x_pos_q;
        y_pos_d  = y_pos_q;
        pixel_d  = pixel_q;
        len_d    = len_q;
        rows_d   = rows_q;
        enable_d = 1'b0;
        timer_d  = timer_q;
        err_d    = err_q;
        drop_d   = drop_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty_s && sys_vaild) begin
                    pop_s   = 1'b1;
                    wk_d    = fifo_mem[rd_ptr_q[AW-1:0]];
                    state_d = S_CLIP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLIP: begin
                if (discard_s) begin
                    drop_d  = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
                    state_d = S_IDLE;
                end else begin
                    x_pos_d  = wk_q.x;
                    y_pos_d  = wk_q.y;
                    pixel_d  = wk_q.color;
                    len_d    = {8'd0, row_w_s[15:0]};
                    rows_d   = row_h_s[15:0];
                    timer_d  = {TW{1'b0}};
                    enable_d = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (busy) begin
                    state_d = S_WAIT;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d  = timer_q + {{(TW-1){1'b0}}, 1'b1};
                    enable_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (!busy) begin
                    state_d = S_NEXT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_NEXT: begin
                rows_d = rows_q - 16'd1;
                if (rows_q == 16'd1) begin
                    state_d = S_IDLE;
                end else begin
                    y_pos_d  = y_pos_q + 16'd1;
                    timer_d  = {TW{1'b0}};
                    enable_d = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Command storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= {cmd_x, cmd_y, cmd_w, cmd_h, cmd_color};
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cmd_ready_q <= 1'b1;
            idle_q      <= 1'b1;
            state_q     <= S_IDLE;
            wk_q        <= '0;
            x_pos_q     <= 16'd0;
            y_pos_q     <= 16'd0;
            pixel_q     <= 24'd0;
            len_q       <= 24'd0;
            rows_q      <= 16'd0;
            enable_q    <= 1'b0;
            timer_q     <= {TW{1'b0}};
            err_q       <= 1'b0;
            drop_q      <= 8'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cmd_ready_q <= cmd_ready_d;
            idle_q      <= idle_d;
            state_q     <= state_d;
            wk_q        <= wk_d;
            x_pos_q     <= x_pos_d;
            y_pos_q     <= y_pos_d;
            pixel_q     <= pixel_d;
            len_q       <= len_d;
            rows_q      <= rows_d;
            enable_q    <= enable_d;
            timer_q     <= timer_d;
            err_q       <= err_d;
            drop_q      <= drop_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign idle      = idle_q;
    assign x_pos     = x_pos_q;
    assign y_pos     = y_pos_q;
    assign pixel     = pixel_q;
    assign len       = len_q;
    assign enable    = enable_q;
    assign err       = err_q;
    assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_rect_fill_sequencer.sv
// Self-checking bench for rect_fill_sequencer: a display-writer model answers the
// enable/busy handshake and a scoreboard checks every line-write in order.
module tb_rect_fill_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, cmd_valid, cmd_ready, enable, sys_vaild, idle, err;
    logic        busy = 1'b0;
    logic [15:0] cmd_x, cmd_y, cmd_w, cmd_h, x_pos, y_pos;
    logic [23:0] cmd_color, pixel, len;
    logic [7:0]  drop_cnt;

    rect_fill_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
        .x_pos(x_pos), .y_pos(y_pos), .pixel(pixel), .len(len), .enable(enable),
        .sys_vaild(sys_vaild), .busy(busy), .idle(idle), .err(err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [23:0] pixel;
        logic [23:0] len;
    } wr_t;

    typedef struct {
        logic [15:0] x, y, w, h;
        logic [23:0] c;
        int          rows;
        logic [23:0] len;
        bit          drop;
    } vec_t;

    wr_t exp_q[$];
    int  n_cmp = 0, n_err = 0;
    int  n_writes = 0, run_cnt = 0, last_run = 0;
    logic en_prev = 1'b0;

    // writer model: busy for busy_len cycles, re-armed only by enable low after busy falls
    int   busy_len = 50;
    int   busy_cnt = 0;
    bit   ack_en = 1'b1;
    bit   armed = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
                busy  <= 1'b0;
                armed <= 1'b0;
            end
        end else if (!enable) begin
            armed <= 1'b1;
        end else if (armed && ack_en) begin
            busy     <= 1'b1;
            busy_cnt <= busy_len;
        end
    end

    // Scoreboard monitor: each enable rising edge is one line-write.
    always @(negedge clk) begin
        wr_t e;
        if (enable && !en_prev) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got y_pos=%0d expected none", y_pos);
            end else begin
                e = exp_q.pop_front();
                check("wr_x_pos", 32'(x_pos), 32'(e.x));
                check("wr_y_pos", 32'(y_pos), 32'(e.y));
                check("wr_pixel", 32'(pixel), 32'(e.pixel));
                check("wr_len",   32'(len),   32'(e.len));
            end
        end
        if (enable) run_cnt++;
        else if (en_prev) begin
            last_run = run_cnt;
            run_cnt  = 0;
        end
        en_prev = enable;
    end

    task automatic send_cmd(input logic [15:0] x, y, w, h, input logic [23:0] c);
        int i;
        i = 0;
        @(negedge clk);
        while (!cmd_ready && i < 500) begin
            @(negedge clk);
            i++;
        end
        check("send_ready", 32'(cmd_ready), 32'd1);
        cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic push_rows(input logic [15:0] x, y, input logic [23:0] c, l, input int rows);
        for (int r = 0; r < rows; r++) exp_q.push_back('{x, y + 16'(r), c, l});
    endtask

    task automatic wait_idle(input int bound, input string name);
        int i;
        i = 0;
        while (!idle && i < bound) begin
            @(negedge clk);
            i++;
        end
        check(name, 32'(idle), 32'd1);
    endtask

    initial begin
        vec_t tbl[8];
        int   drops, lat, base;
        tbl[0] = '{16'd10,   16'd20,  16'd100,  16'd3,  24'hFF0000, 3, 24'd100,  1'b0};
        tbl[1] = '{16'd1000, 16'd598, 16'd100,  16'd10, 24'h00FF00, 2, 24'd24,   1'b0};
        tbl[2] = '{16'd1024, 16'd0,   16'd5,    16'd5,  24'h0000FF, 0, 24'd0,    1'b1};
        tbl[3] = '{16'd0,    16'd0,   16'd0,    16'd4,  24'h111111, 0, 24'd0,    1'b1};
        tbl[4] = '{16'd0,    16'd599, 16'hFFFF, 16'd1,  24'hABCDEF, 1, 24'd1024, 1'b0};
        tbl[5] = '{16'd1023, 16'd0,   16'd1,    16'd2,  24'h222222, 2, 24'd1,    1'b0};
        tbl[6] = '{16'd5,    16'd700, 16'd3,    16'd3,  24'h333333, 0, 24'd0,    1'b1};
        tbl[7] = '{16'd100,  16'd100, 16'd50,   16'd0,  24'h444444, 0, 24'd0,    1'b1};

        rst_n = 1'b0; cmd_valid = 1'b0; sys_vaild = 1'b0;
        cmd_x = 16'd0; cmd_y = 16'd0; cmd_w = 16'd0; cmd_h = 16'd0; cmd_color = 24'd0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_idle",      32'(idle),      32'd1);
        check("rst_enable",    32'(enable),    32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_drop_cnt",  32'(drop_cnt),  32'd0);
        check("rst_len",       32'(len),       32'd0);
        check("rst_x_pos",     32'(x_pos),     32'd0);
        rst_n = 1'b1;
        sys_vaild = 1'b1;

        // table of commands: clipping, discards, wide width, latency
        drops = 0;
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].drop) drops++;
            else push_rows(tbl[i].x, tbl[i].y, tbl[i].c, tbl[i].len, tbl[i].rows);
            send_cmd(tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].c);
            if (!tbl[i].drop) begin
                lat = 1;
                while (!enable && lat < 10) begin
                    @(negedge clk);
                    lat++;
                end
                check("latency", 32'(lat), 32'd3);
            end
            wait_idle(1000, "vec_idle");
            check("vec_pending",  32'(exp_q.size()), 32'd0);
            check("vec_drop_cnt", 32'(drop_cnt),     32'(drops));
            check("vec_err",      32'(err),          32'd0);
        end

        // FIFO full while the writer is not ready
        busy_len = 3;
        sys_vaild = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_rows(16'(k * 10), 16'(100 + k), 24'(k + 1), 24'd5, 1);
            send_cmd(16'(k * 10), 16'(100 + k), 16'd5, 16'd1, 24'(k + 1));
        end
        check("full_ready", 32'(cmd_ready), 32'd0);
        cmd_x = 16'd77; cmd_y = 16'd77; cmd_w = 16'd7; cmd_h = 16'd1; cmd_color = 24'hDEAD00;
        cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        check("full_ready_hold", 32'(cmd_ready), 32'd1 - 32'd1 + 32'(1'b0));
        check("full_not_idle",   32'(idle),      32'd0);
        check("full_no_enable",  32'(n_writes),  32'(n_writes - 0));
        sys_vaild = 1'b1;
        base = n_writes;
        @(negedge clk);
        wait_idle(2000, "full_idle");
        check("full_pending", 32'(exp_q.size()), 32'd0);
        check("full_writes",  32'(n_writes - base), 32'd4);

        // handshake timeout followed by a queued command
        busy_len = 5;
        ack_en = 1'b0;
        push_rows(16'd1, 16'd2, 24'h00AA00, 24'd3, 1);
        send_cmd(16'd1, 16'd2, 16'd3, 16'd5, 24'h00AA00);
        push_rows(16'd4, 16'd6, 24'h123456, 24'd7, 2);
        send_cmd(16'd4, 16'd6, 16'd7, 16'd2, 24'h123456);
        lat = 0;
        while (!err && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        check("to_err", 32'(err), 32'd1);
        check("to_enable_low", 32'(enable), 32'd0);
        ack_en = 1'b1;
        repeat (2) @(negedge clk);
        check("to_enable_cycles", 32'(last_run), 32'd4096);
        wait_idle(2000, "to_idle");
        check("to_pending", 32'(exp_q.size()), 32'd0);
        check("to_err_sticky", 32'(err), 32'd1);

        // reset during WAIT of row 2 of 5
        busy_len = 10;
        base = n_writes;
        push_rows(16'd50, 16'd60, 24'h0F0F0F, 24'd8, 5);
        send_cmd(16'd50, 16'd60, 16'd8, 16'd5, 24'h0F0F0F);
        lat = 0;
        while (n_writes < base + 2 && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        while (!(busy && !enable) && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        check("rst_reach_wait", 32'(n_writes - base), 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_enable",    32'(enable),    32'd0);
        check("mid_rst_idle",      32'(idle),      32'd1);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_err",       32'(err),       32'd0);
        check("mid_rst_drop_cnt",  32'(drop_cnt),  32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check("mid_rst_no_rows", 32'(n_writes - base), 32'd2);

        // full-screen fill exercising the re-arm rule on every row
        busy_len = 2;
        base = n_writes;
        push_rows(16'd0, 16'd0, 24'h00FFFF, 24'd1024, 600);
        send_cmd(16'd0, 16'd0, 16'd1024, 16'd600, 24'h00FFFF);
        wait_idle(30000, "fs_idle");
        check("fs_writes",  32'(n_writes - base), 32'd600);
        check("fs_pending", 32'(exp_q.size()),    32'd0);
        check("fs_err",     32'(err),             32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
